// File: rtl/imem_loader_pkg.sv
// Shared types for the boot-time instruction memory loader.
// State encoding and error codes reported on err_code.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        WR,
        CSUM,
        DONE,
        ERR
    } state_e;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_CSUM    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/imem_loader_timeout.sv
// Idle-cycle watchdog for the loader byte stream.
// expired_o fires on the TIMEOUT-th consecutive enabled cycle.
module loader_timeout #(
    parameter int unsigned TIMEOUT = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CW = $clog2(TIMEOUT);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = en_i && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot loader: packs a LE byte stream into 32-bit words, writes
// instruction RAM and holds the CPU in reset until the image checks out.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned            ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]      BASE_ADDR = '0,
    parameter int unsigned            MAX_WORDS = 4096,
    parameter int unsigned            TIMEOUT   = 1000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_wa,
    output logic [31:0]       mem_wd,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code
);

    localparam int unsigned WW = $clog2(MAX_WORDS + 1);

    state_e            state_q, state_d;
    logic [1:0]        bidx_q, bidx_d;
    logic [WW-1:0]     widx_q, widx_d;
    logic [WW-1:0]     len_q, len_d;
    logic [31:0]       word_q, word_d;
    logic [7:0]        sum_q, sum_d;
    logic [ADDR_W-1:0] wa_q, wa_d;
    logic [31:0]       wd_q, wd_d;
    logic [1:0]        err_q, err_d;

    logic              xfer;
    logic [31:0]       word_nx;
    logic [7:0]        sum_nx;
    logic [WW-1:0]     widx_inc;
    logic              len_bad;
    logic              tmo_clr;
    logic              tmo_en;
    logic              tmo_exp;

    assign rx_ready = (state_q == LEN) || (state_q == DATA) || (state_q == CSUM);
    assign xfer     = rx_valid && rx_ready;
    assign word_nx  = {rx_data, word_q[31:8]};
    assign sum_nx   = sum_q + rx_data;
    assign widx_inc = widx_q + WW'(1);
    assign len_bad  = (word_nx == 32'd0) || (word_nx > 32'(MAX_WORDS));

    always_comb begin
        state_d = state_q;
        bidx_d  = bidx_q;
        widx_d  = widx_q;
        len_d   = len_q;
        word_d  = word_q;
        sum_d   = sum_q;
        wa_d    = wa_q;
        wd_d    = wd_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE, ERR: begin
                if (start) begin
                    state_d = LEN;
                    bidx_d  = '0;
                    widx_d  = '0;
                    word_d  = '0;
                    sum_d   = '0;
                    err_d   = ERR_NONE;
                end
            end
            LEN: begin
                if (xfer) begin
                    word_d = word_nx;
                    sum_d  = sum_nx;
                    bidx_d = bidx_q + 2'd1;
                    if (bidx_q == 2'd3) begin
                        if (len_bad) begin
                            state_d = ERR;
                            err_d   = ERR_LEN;
                        end else begin
                            state_d = DATA;
                            len_d   = word_nx[WW-1:0];
                        end
                    end
                end else if (tmo_exp) begin
                    state_d = ERR;
                    err_d   = ERR_TIMEOUT;
                end
            end
            DATA: begin
                if (xfer) begin
                    word_d = word_nx;
                    sum_d  = sum_nx;
                    bidx_d = bidx_q + 2'd1;
                    if (bidx_q == 2'd3) begin
                        state_d = WR;
                        wa_d    = BASE_ADDR + (ADDR_W'(widx_q) << 2);
                        wd_d    = word_nx;
                    end
                end else if (tmo_exp) begin
                    state_d = ERR;
                    err_d   = ERR_TIMEOUT;
                end
            end
            WR: begin
                widx_d  = widx_inc;
                state_d = (widx_inc == len_q) ? CSUM : DATA;
            end
            CSUM: begin
                if (xfer) begin
                    if (rx_data == sum_q) begin
                        state_d = DONE;
                    end else begin
                        state_d = ERR;
                        err_d   = ERR_CSUM;
                    end
                end else if (tmo_exp) begin
                    state_d = ERR;
                    err_d   = ERR_TIMEOUT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bidx_q  <= '0;
            widx_q  <= '0;
            len_q   <= '0;
            word_q  <= '0;
            sum_q   <= '0;
            wa_q    <= '0;
            wd_q    <= '0;
            err_q   <= ERR_NONE;
        end else begin
            state_q <= state_d;
            bidx_q  <= bidx_d;
            widx_q  <= widx_d;
            len_q   <= len_d;
            word_q  <= word_d;
            sum_q   <= sum_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
        end
    end

    // WR freezes the watchdog; any state change restarts it
    assign tmo_clr = xfer || (state_d != state_q);
    assign tmo_en  = rx_ready && !xfer;

    loader_timeout #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (tmo_clr),
        .en_i     (tmo_en),
        .expired_o(tmo_exp)
    );

    assign mem_we   = (state_q == WR);
    assign mem_wa   = wa_q;
    assign mem_wd   = wd_q;
    assign busy     = rx_ready || (state_q == WR);
    assign cpu_hold = busy || (state_q == ERR);
    assign done     = (state_q == DONE);
    assign error    = (state_q == ERR);
    assign err_code = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: random frames against a
// frame-level reference model, plus directed boot scenarios.
module tb_imem_loader;

    localparam int          MAXW = 8;
    localparam int          TO   = 20;
    localparam logic [31:0] BASE = 32'h0;

    typedef logic [7:0]  bq_t[$];
    typedef logic [31:0] wq_t[$];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        mem_we;
    logic [31:0] mem_wa;
    logic [31:0] mem_wd;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  err_code;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_wr_q[$];
    int          exp_evt_q[$];

    imem_loader #(
        .ADDR_W   (32),
        .BASE_ADDR(BASE),
        .MAX_WORDS(MAXW),
        .TIMEOUT  (TO)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .mem_we  (mem_we),
        .mem_wa  (mem_wa),
        .mem_wd  (mem_wd),
        .cpu_hold(cpu_hold),
        .busy    (busy),
        .done    (done),
        .error   (error),
        .err_code(err_code)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got %0h expected nothing", name, act);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rx_ready"}, rx_ready, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_wa"}, mem_wa, 0);
        chk({tag, "_mem_wd"}, mem_wd, 0);
        chk({tag, "_cpu_hold"}, cpu_hold, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_err_code"}, err_code, 0);
    endtask

    // Monitor: consumes expected writes/outcomes as the DUT presents them
    initial begin
        logic [63:0] e;
        int          ev;
        logic        err_prev;
        err_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                err_prev = 1'b0;
            end else begin
                if (mem_we) begin
                    chk("we_vs_ready", rx_ready, 0);
                    if (exp_wr_q.size() == 0) begin
                        fail_now("unexpected_write", {mem_wa, mem_wd});
                    end else begin
                        e = exp_wr_q.pop_front();
                        chk("mem_wa", mem_wa, e[63:32]);
                        chk("mem_wd", mem_wd, e[31:0]);
                    end
                end
                if (busy && rx_valid && !rx_ready)
                    chk("stall_only_in_wr", mem_we, 1);
                if (!busy && rx_valid)
                    chk("ready_when_idle", rx_ready, 0);
                if (busy)
                    chk("hold_while_busy", cpu_hold, 1);
                if (done) begin
                    chk("done_cpu_hold", cpu_hold, 0);
                    chk("done_error", error, 0);
                    if (exp_evt_q.size() == 0) begin
                        fail_now("unexpected_done", 1);
                    end else begin
                        ev = exp_evt_q.pop_front();
                        chk("outcome_done", 0, ev);
                    end
                end
                if (error && !err_prev) begin
                    chk("err_cpu_hold", cpu_hold, 1);
                    if (exp_evt_q.size() == 0) begin
                        fail_now("unexpected_error", err_code);
                    end else begin
                        ev = exp_evt_q.pop_front();
                        chk("err_code", err_code, ev);
                    end
                end
                err_prev = error;
            end
        end
    end

    task automatic build(input logic [31:0] nf, input wq_t w,
                         input logic [7:0] delta, output bq_t fr);
        logic [7:0] s;
        s = 8'h00;
        fr.delete();
        for (int i = 0; i < 4; i++) fr.push_back(nf[8*i +: 8]);
        foreach (w[j])
            for (int i = 0; i < 4; i++) fr.push_back(w[j][8*i +: 8]);
        foreach (fr[i]) s = s + fr[i];
        fr.push_back(s + delta);
    endtask

    // Frame-level reference: what the loader must write and how it ends
    task automatic model(input bq_t fr, input int stall_at, output int nsend);
        int          n;
        int          code;
        logic [31:0] nf;
        logic [31:0] wd;
        logic [7:0]  s;
        nf   = {fr[3], fr[2], fr[1], fr[0]};
        code = 0;
        if (stall_at >= 0 && stall_at < 4) begin
            nsend = stall_at;
            code  = 3;
        end else if (nf == 0 || nf > MAXW) begin
            nsend = 4;
            code  = 1;
        end else begin
            n     = int'(nf);
            nsend = 4 + 4 * n + 1;
            for (int w = 0; w < n; w++) begin
                if (stall_at >= 0 && stall_at < 8 + 4 * w) begin
                    nsend = stall_at;
                    code  = 3;
                    break;
                end
                wd = {fr[4*w+7], fr[4*w+6], fr[4*w+5], fr[4*w+4]};
                exp_wr_q.push_back({BASE + 32'(4 * w), wd});
            end
            if (code == 0) begin
                if (stall_at == 4 + 4 * n) begin
                    nsend = stall_at;
                    code  = 3;
                end else begin
                    s = 8'h00;
                    for (int i = 0; i < 4 + 4 * n; i++) s = s + fr[i];
                    code = (fr[4+4*n] == s) ? 0 : 2;
                end
            end
        end
        exp_evt_q.push_back(code);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_hold", cpu_hold, 1);
        chk("start_error_clr", error, 0);
        chk("start_code_clr", err_code, 0);
    endtask

    task automatic send_byte(input logic [7:0] b, output bit ok);
        ok       = 1'b0;
        rx_data  = b;
        rx_valid = 1'b1;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            if (rx_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
                return;
            end
        end
        chk("rx_ready_wait", 0, 1);
    endtask

    task automatic idle_gap(input int g, input bit ps);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        for (int j = 0; j < g; j++) begin
            start = ps && (j == 0);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
    endtask

    task automatic run_frame(input bq_t fr, input int max_gap,
                             input int stall_at, input bit ps);
        int nsend;
        int k;
        bit ok;
        model(fr, stall_at, nsend);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        do_start();
        for (int i = 0; i < nsend; i++) begin
            send_byte(fr[i], ok);
            if (!ok) break;
            if (i + 1 < nsend && max_gap > 0)
                idle_gap($urandom_range(0, max_gap), ps);
        end
        rx_valid = 1'b0;
        if (stall_at >= 0) begin
            k = 0;
            while (!error && k < TO + 6) begin
                @(negedge clk);
                k++;
            end
            chk($sformatf("timeout_window_edges_%0d", k - 1),
                (k - 1 >= TO) && (k - 1 <= TO + 2), 1);
        end
        k = 0;
        while ((exp_evt_q.size() + exp_wr_q.size()) != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("outcome_pending", exp_evt_q.size() + exp_wr_q.size(), 0);
        exp_evt_q.delete();
        exp_wr_q.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bq_t         fr;
        wq_t         w;
        wq_t         w1;
        logic [31:0] nf;
        logic [7:0]  delta;
        int          n;
        int          kind;
        int          stall;
        int          mg;
        int          r;
        bit          ok;
        bit          ps;

        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;

        w1.delete();
        w1.push_back(32'hfe010113);
        w1.push_back(32'h00812e23);

        build(32'd2, w1, 8'd0, fr);
        run_frame(fr, 2, -1, 1'b0);
        chk("t1_cpu_hold", cpu_hold, 0);
        chk("t1_error", error, 0);

        build(32'd2, w1, 8'd1, fr);
        run_frame(fr, 1, -1, 1'b0);
        chk("t2_error", error, 1);
        chk("t2_err_code", err_code, 2);
        chk("t2_cpu_hold", cpu_hold, 1);

        w.delete();
        build(32'd0, w, 8'd0, fr);
        run_frame(fr, 0, -1, 1'b0);
        chk("t3_len0_code", err_code, 1);
        build(32'(MAXW + 1), w, 8'd0, fr);
        run_frame(fr, 0, -1, 1'b0);
        chk("t3_lenmax_code", err_code, 1);

        build(32'd2, w1, 8'd0, fr);
        run_frame(fr, 0, 6, 1'b0);
        chk("t4_err_code", err_code, 3);
        chk("t4_cpu_hold", cpu_hold, 1);

        repeat (2) @(posedge clk);
        #1;
        do_start();
        exp_wr_q.push_back({BASE, 32'hfe010113});
        for (int i = 0; i < 10; i++) send_byte(fr[i], ok);
        chk("t5_first_write_seen", exp_wr_q.size(), 0);
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        #1;
        chk_zero("t5_async");
        exp_wr_q.delete();
        exp_evt_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_frame(fr, 0, -1, 1'b0);
        chk("t5_reload_error", error, 0);

        w.delete();
        for (int j = 0; j < MAXW; j++) w.push_back($urandom);
        build(32'(MAXW), w, 8'd0, fr);
        run_frame(fr, 0, -1, 1'b0);

        for (int it = 0; it < 30; it++) begin
            kind  = $urandom_range(0, 9);
            n     = $urandom_range(1, MAXW);
            stall = -1;
            delta = 8'd0;
            w.delete();
            for (int j = 0; j < n; j++) w.push_back($urandom);
            nf = 32'(n);
            if (kind == 0) begin
                nf = $urandom_range(0, 1) ? 32'd0 : ($urandom | 32'h100);
            end else if (kind == 1) begin
                delta = 8'($urandom_range(1, 255));
            end else if (kind == 2) begin
                stall = $urandom_range(0, 4 + 4 * n);
            end
            r  = $urandom_range(0, 4);
            mg = (r == 0) ? 0 : (r == 4) ? TO - 2 : 3;
            ps = 1'($urandom_range(0, 1));
            build(nf, w, delta, fr);
            run_frame(fr, mg, stall, ps);
        end

        chk("final_writes_left", exp_wr_q.size(), 0);
        chk("final_events_left", exp_evt_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
